// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding shared by the ALU datapath, the execute stage and its bench
package alu_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_EQU, OP_BLT} alu_op_e;
  // Compare ops produce a predicate, not a value worth accumulating
  function automatic logic writes_acc(input logic [2:0] op);
    return !(op == OP_EQU || op == OP_BLT);
  endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational result/flag datapath
//   op            opcode (alu_op_e encoding)
//   a, b          operands
//   y             result
//   zero          y is all zeros
//   carry         adder carry-out (for subtract, 1 = no borrow)
//   overflow      signed overflow of the adder
module alu
  import alu_pkg::*;
#(
  parameter int width = 4
) (
  input  logic [2:0]       op,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);
  logic [width-1:0] bx;
  logic [width-1:0] sum;
  // The adder always runs; op[0] selects subtract (A + ~B + 1) so flags track it for every opcode
  assign bx = op[0] ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, bx} + (width+1)'(op[0]);
  assign overflow = (a[width-1] == bx[width-1]) && (sum[width-1] != a[width-1]);
  assign y = (op == OP_ADD || op == OP_SUB) ? sum :
             op == OP_NOT ? ~a :
             op == OP_AND ? a & b :
             op == OP_OR  ? a | b :
             op == OP_XOR ? a ^ b :
             op == OP_EQU ? width'(a == b) :
                            width'($signed(a) < $signed(b));
  assign zero = y == '0;
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: single-entry valid/ready execute stage with accumulator and completion counter
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready             request handshake; in_op, in_a, in_b, in_acc request fields
//   out_valid/out_ready           result handshake; out_result, out_zero/carry/overflow registered result
//   acc                           accumulator (operand A when in_acc=1)
//   op_count                      completed output handshakes, wrapping
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_overflow,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d, acc_q, acc_d, op_a, y;
  logic [2:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, drain, zero, carry, overflow;
  assign op_a = in_acc ? acc_q : in_a;
  alu #(.width(WIDTH)) u_alu (
    .op(in_op), .a(op_a), .b(in_b), .y(y), .zero(zero), .carry(carry), .overflow(overflow)
  );
  // Downstream taking the held result frees the slot in the same cycle, so no bubble
  assign in_ready = !valid_q || out_ready;
  assign accept = in_valid && in_ready;
  assign drain = valid_q && out_ready;
  always_comb begin
    valid_d = accept ? 1'b1 : (drain ? 1'b0 : valid_q);
    result_d = accept ? y : result_q;
    flags_d = accept ? {zero, carry, overflow} : flags_q;
    acc_d = (accept && writes_acc(in_op)) ? y : acc_q;
    cnt_d = drain ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      result_q <= '0;
      flags_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      result_q <= result_d;
      flags_q <= flags_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = valid_q;
  assign out_result = result_q;
  assign {out_zero, out_carry, out_overflow} = flags_q;
  assign acc = acc_q;
  assign op_count = cnt_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: scoreboard bench for alu_exec_stage with directed vectors
module tb_alu_exec_stage;
  import alu_pkg::*;
  localparam int W = 4;
  localparam int C = 8;
  logic clk = 0, rst_n = 0, in_valid = 0, in_acc = 0, out_ready = 1;
  logic [2:0] in_op = 0;
  logic [W-1:0] in_a = 0, in_b = 0;
  logic in_ready, out_valid, out_zero, out_carry, out_overflow;
  logic [W-1:0] out_result, acc;
  logic [C-1:0] op_count;
  alu_exec_stage #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_carry(out_carry),
    .out_overflow(out_overflow), .acc(acc), .op_count(op_count)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [W-1:0] r; logic z, c, v;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Monitor: a result is consumed at the next edge whenever out_valid && out_ready
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got result %0h expected none", out_result);
      end else begin
        e = q.pop_front();
        chk("sb_result", out_result, e.r);
        chk("sb_zero", out_zero, e.z);
        chk("sb_carry", out_carry, e.c);
        chk("sb_overflow", out_overflow, e.v);
      end
    end
  end
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ac, input logic [W-1:0] r, input logic z, input logic c,
                      input logic v);
    int t = 0;
    in_op = op; in_a = a; in_b = b; in_acc = ac; in_valid = 1;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end else q.push_back('{r, z, c, v});
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int snap, t0;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_flags", {out_zero, out_carry, out_overflow}, 0);
    chk("rst_acc", acc, 0);
    chk("rst_count", op_count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1;
    #1 chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(OP_ADD, 7, 1, 0, 8, 0, 0, 1);
    chk("add_acc", acc, 8);
    send(OP_SUB, 3, 3, 0, 0, 1, 1, 0);
    chk("sub_acc", acc, 0);
    send(OP_BLT, 8, 1, 0, 1, 0, 1, 1);
    chk("blt_acc", acc, 0);
    send(OP_NOT, 5, 3, 0, 10, 0, 0, 1);
    chk("not_acc", acc, 10);
    send(OP_OR, 4, 1, 0, 5, 0, 0, 0);
    send(OP_XOR, 9, 9, 0, 0, 1, 1, 0);
    send(OP_EQU, 9, 9, 0, 1, 0, 1, 1);
    chk("equ_acc", acc, 0);
    idle(2);
    chk("count_7", op_count, 7);
    // Accumulate from a fresh reset; in_a is junk to prove acc is the A operand
    rst_n = 0;
    #1 rst_n = 1;
    idle(1);
    send(OP_ADD, 9, 5, 1, 5, 0, 0, 0);
    chk("accum1_acc", acc, 5);
    send(OP_ADD, 9, 5, 1, 10, 0, 0, 1);
    chk("accum2_acc", acc, 10);
    idle(2);
    // Backpressure then same-edge drain and accept
    out_ready = 0;
    send(OP_ADD, 2, 3, 0, 5, 0, 0, 0);
    snap = op_count;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", out_result, 5);
      chk("bp_flags", {out_zero, out_carry, out_overflow}, 0);
      chk("bp_count", op_count, snap);
    end
    @(posedge clk); #1;
    out_ready = 1;
    send(OP_AND, 6, 3, 0, 2, 0, 1, 0);
    chk("bp_count_inc", op_count, (snap + 1) % 256);
    chk("bp_new_result", out_result, 2);
    chk("bp_new_valid", out_valid, 1);
    idle(2);
    // Reset while FULL discards the held result
    out_ready = 0;
    send(OP_ADD, 1, 1, 0, 2, 0, 0, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rf_valid", out_valid, 0);
    chk("rf_result", out_result, 0);
    chk("rf_acc", acc, 0);
    chk("rf_count", op_count, 0);
    chk("rf_in_ready", in_ready, 1);
    q.delete();
    out_ready = 1;
    @(negedge clk) rst_n = 1;
    #1 chk("rf_post_in_ready", in_ready, 1);
    @(posedge clk); #1;
    // 256 back-to-back transactions, one per cycle
    t0 = cyc;
    for (int i = 0; i < 256; i++) send(OP_ADD, 4'(i), 0, 0, 4'(i), 4'(i) == 0, 0, 0);
    chk("b2b_cycles", cyc - t0, 256);
    chk("b2b_acc", acc, 15);
    idle(1);
    chk("wrap_count", op_count, 0);
    chk("wrap_valid", out_valid, 0);
    chk("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand/result width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, giving the completed-operation counter width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  upstream request valid.
REQ-006 in_ready  output  1  stage can accept a request this cycle.
REQ-007 in_op  input  3  opcode: 0 add, 1 sub, 2 not, 3 and, 4 or, 5 xor, 6 equ, 7 blt.
REQ-008 in_a  input  WIDTH  operand A, used when in_acc=0.
REQ-009 in_b  input  WIDTH  operand B.
REQ-010 in_acc  input  1  select internal accumulator as operand A.
REQ-011 out_valid  output  1  registered result available.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_result  output  WIDTH  registered ALU result.
REQ-014 out_zero, out_carry, out_overflow  output  1 each  registered ALU flags.
REQ-015 acc  output  WIDTH  current accumulator value.
REQ-016 op_count  output  CNT_W  number of completed output handshakes.

Function
REQ-017 Accept SHALL occur on a cycle with in_valid && in_ready; drain SHALL occur on a cycle with out_valid && out_ready.
REQ-018 in_ready SHALL equal !out_valid || out_ready (combinational; single-entry pipeline register, no bubble on back-to-back traffic).
REQ-019 Two states: EMPTY (out_valid=0) and FULL (out_valid=1); state SHALL be derived from out_valid.
REQ-020 EMPTY -> FULL on accept; FULL -> EMPTY on drain without accept; FULL -> FULL on simultaneous drain and accept (new result replaces old in the same edge).
REQ-021 Latency SHALL be exactly one cycle: a request accepted at edge N SHALL appear on out_* after edge N with out_valid=1.
REQ-022 Operand A SHALL be acc when in_acc=1, else in_a; operand B SHALL always be in_b.
REQ-023 Result and flags SHALL be computed combinationally from the selected operands and in_op, then registered on accept only.
REQ-024 Arithmetic SHALL be WIDTH-bit two's complement: sub = A + ~B + 1; carry is adder carry-out (for sub, 1 means no borrow); overflow is signed overflow of the add/sub path.
REQ-025 For ops 2-7, out_carry/out_overflow SHALL still reflect the adder path for the current opcode's bit0; out_zero SHALL be 1 iff out_result is all zeros, for every op.
REQ-026 equ SHALL produce 1 iff A==B, else 0; blt SHALL produce 1 iff A<B signed; both zero-extended to WIDTH.
REQ-027 On accept with in_op in 0..5, acc SHALL load the new result at the same edge; ops 6 and 7 SHALL leave acc unchanged.
REQ-028 A request accepted the cycle after an acc-writing accept SHALL observe the updated acc.
REQ-029 While out_valid=1 and out_ready=0, out_result and all flags SHALL hold stable.
REQ-030 op_count SHALL increment by 1 on each drain, wrapping from all-ones to 0.
REQ-031 All eight opcodes are defined; no illegal-op handling.

Reset
REQ-032 On rst_n low, immediately and without clk: out_valid=0, out_result=0, all flags=0, acc=0, op_count=0.
REQ-033 Reset asserted while FULL SHALL discard the held result; no drain or count is recorded.
REQ-034 in_ready SHALL be 1 while in reset and on the first cycle after release.

Structure
REQ-035 Opcode constants (OP_ADD..OP_BLT) SHALL live in shared package alu_pkg.
REQ-036 The combinational result/flag datapath SHALL be one sub-module instance of alu (parameter width=WIDTH); this block adds operand select, pipeline register, accumulator and counter.

Verification (WIDTH=4)
REQ-037 add a=7, b=1 -> next cycle out_result=8, overflow=1, carry=0, zero=0, acc=8.
REQ-038 sub a=3, b=3 -> out_result=0, zero=1, carry=1, overflow=0; then blt a=8 (-8), b=1 -> out_result=1, acc remains 0.
REQ-039 Accumulate: after reset, add in_acc=1, b=5 -> acc=5; next cycle add in_acc=1, b=5 -> out_result=10, overflow=1, acc=10.
REQ-040 Backpressure: hold out_ready=0 for 3 cycles after a result -> in_ready=0, out_* stable, op_count unchanged; raise out_ready with a new in_valid -> same-edge drain and accept, op_count+1, new result next cycle.
REQ-041 Reset while FULL -> out_valid=0, acc=0, op_count=0 immediately, before any clock edge.
REQ-042 256 back-to-back transactions with out_ready=1 -> op_count returns to 0, one result per cycle, no bubbles.
